// File: rtl/mem_responder_if.sv
// CPU-bus memory port: request lines from the control unit,
// read data and completion status back from the responder.
interface mem_responder_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              Read;
  logic              ramWE;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              mem_ready;
  logic              busy;
  logic              proto_err;

  modport master (
    output Read, ramWE, addr, wdata,
    input  rdata, mem_ready, busy, proto_err
  );

  modport slave (
    input  Read, ramWE, addr, wdata,
    output rdata, mem_ready, busy, proto_err
  );
endinterface

// File: rtl/mem_responder.sv
// Word-array memory responder with programmable wait states
// and a 4-phase Read/ramWE -> mem_ready handshake.
module mem_responder #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] RD_L = 4'(RD_LAT);
  localparam logic [3:0] WR_L = 4'(WR_LAT);

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    WAIT,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic              req_q;
  logic              op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              perr_q, perr_d;

  logic              req;
  logic              rise;
  logic              op_line;
  logic              commit;
  logic              wr_commit;
  logic [3:0]        lat;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_comb begin
    req     = bus.Read | bus.ramWE;
    rise    = req & ~req_q;
    op_line = op_q ? bus.ramWE : bus.Read;
    lat     = op_q ? WR_L : RD_L;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    perr_d  = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          if (bus.Read && bus.ramWE) begin
            perr_d = 1'b1;
          end else begin
            op_d    = bus.ramWE;
            addr_d  = bus.addr;
            wdata_d = bus.wdata;
            state_d = ACCEPT;
          end
        end
      end
      ACCEPT: begin
        cnt_d = lat - 4'd1;
        if (!op_line) begin
          state_d = IDLE;
        end else if (lat == 4'd1) begin
          commit  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!op_line) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            commit  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (!op_line) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    wr_commit = commit & op_q;
    rdata_d   = (commit && !op_q) ? mem_q[addr_q] : rdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      op_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      perr_q  <= perr_d;
    end
  end

  // Array keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (wr_commit) mem_q[addr_q] <= wdata_q;
  end

  assign bus.rdata     = rdata_q;
  assign bus.mem_ready = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.proto_err = perr_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: vector table with response scoreboard,
// plus hand sequences for protocol error, abort and reset.
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        sel;
  logic        rd, we;
  logic [8:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        mem_ready, busy, proto_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_W(9), .DATA_W(32)) ifa ();
  mem_responder_if #(.ADDR_W(9), .DATA_W(32)) ifb ();

  assign ifa.Read  = rd & ~sel;
  assign ifa.ramWE = we & ~sel;
  assign ifa.addr  = addr;
  assign ifa.wdata = wdata;
  assign ifb.Read  = rd & sel;
  assign ifb.ramWE = we & sel;
  assign ifb.addr  = addr;
  assign ifb.wdata = wdata;

  assign rdata     = sel ? ifb.rdata : ifa.rdata;
  assign mem_ready = sel ? ifb.mem_ready : ifa.mem_ready;
  assign busy      = sel ? ifb.busy : ifa.busy;
  assign proto_err = sel ? ifb.proto_err : ifa.proto_err;

  mem_responder #(.RD_LAT(2), .WR_LAT(1)) dut_a (
    .clk(clk), .rst(rst_a), .bus(ifa)
  );
  mem_responder #(.RD_LAT(2), .WR_LAT(4)) dut_b (
    .clk(clk), .rst(rst_b), .bus(ifb)
  );

  typedef struct {
    bit          wr;
    logic [8:0]  addr;
    logic [31:0] data;
    int          hold;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  typedef struct {
    bit          wr;
    logic [31:0] rd;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[9];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit   seen = 1'b0;
    exp_t e;
    sb.push_back('{v.wr, v.exp_rd, v.exp_lat});
    addr  = v.addr;
    wdata = v.data;
    if (v.wr) we = 1'b1;
    else      rd = 1'b1;
    for (int k = 1; k <= v.hold || (!seen && k <= 40); k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        addr  = ~v.addr;
        wdata = ~v.data;
      end
      chk("busy_during", 32'(busy), 32'd1);
      if (seen) begin
        chk("ready_held", 32'(mem_ready), 32'd1);
      end else if (mem_ready) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          chk("sb_empty", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("latency", 32'(k), 32'(e.lat));
          if (!e.wr) chk("rdata", rdata, e.rd);
        end
      end
    end
    if (!seen) begin
      chk("ready_timeout", 32'd0, 32'd1);
      if (sb.size() != 0) void'(sb.pop_front());
    end
    rd = 1'b0;
    we = 1'b0;
    @(posedge clk); #1;
    chk("ready_drop", 32'(mem_ready), 32'd0);
    chk("busy_drop", 32'(busy), 32'd0);
  endtask

  function automatic vec_t rvec(input logic [8:0] a,
                                input logic [31:0] x);
    rvec = '{1'b0, a, 32'h0, 3, x, 3};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 9'h005, 32'hDEADBEEF, 6, 32'h0, 2};
    tbl[1] = '{1'b0, 9'h005, 32'h0, 4, 32'hDEADBEEF, 3};
    tbl[2] = '{1'b0, 9'h005, 32'h0, 10, 32'hDEADBEEF, 3};
    tbl[3] = '{1'b1, 9'h000, 32'h11111111, 3, 32'h0, 2};
    tbl[4] = '{1'b1, 9'h1FF, 32'h00000001, 3, 32'h0, 2};
    tbl[5] = '{1'b0, 9'h1FF, 32'h0, 3, 32'h00000001, 3};
    tbl[6] = '{1'b0, 9'h000, 32'h0, 3, 32'h11111111, 3};
    tbl[7] = '{1'b1, 9'h0FF, 32'hA5A5A5A5, 2, 32'h0, 2};
    tbl[8] = '{1'b0, 9'h0FF, 32'h0, 3, 32'hA5A5A5A5, 3};

    sel = 1'b0; rd = 1'b0; we = 1'b0;
    addr = '0; wdata = '0;
    rst_a = 1'b0; rst_b = 1'b0;
    #2;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ready", 32'(mem_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_perr", 32'(proto_err), 32'd0);
    @(posedge clk); #1;
    rst_a = 1'b1; rst_b = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_vec(tbl[i]);

    // both request lines together: error pulse, no access
    rd = 1'b1; we = 1'b1;
    addr = 9'h005; wdata = 32'h0BAD0BAD;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      chk("perr_pulse", 32'(proto_err), (k == 1) ? 32'd1 : 32'd0);
      chk("perr_ready", 32'(mem_ready), 32'd0);
      chk("perr_busy", 32'(busy), 32'd0);
    end
    rd = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    run_vec(rvec(9'h005, 32'hDEADBEEF));

    sel = 1'b1;
    run_vec('{1'b1, 9'h010, 32'h55AA0000, 5, 32'h0, 5});
    run_vec('{1'b1, 9'h1FF, 32'h0BADF00D, 5, 32'h0, 5});
    run_vec('{1'b1, 9'h000, 32'h00C0FFEE, 5, 32'h0, 5});

    // aborted write: ramWE drops while waiting
    we = 1'b1; addr = 9'h010; wdata = 32'h12345678;
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk); #1;
      chk("abort_ready", 32'(mem_ready), 32'd0);
    end
    we = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk("abort_idle_ready", 32'(mem_ready), 32'd0);
      chk("abort_idle_busy", 32'(busy), 32'd0);
    end
    run_vec(rvec(9'h010, 32'h55AA0000));

    // reset in the middle of a write's wait phase
    we = 1'b1; addr = 9'h1FF; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_b = 1'b0;
    #1;
    chk("arst_rdata", rdata, 32'h0);
    chk("arst_ready", 32'(mem_ready), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_perr", 32'(proto_err), 32'd0);
    we = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(posedge clk); #1;
    run_vec(rvec(9'h1FF, 32'h0BADF00D));
    run_vec(rvec(9'h000, 32'h00C0FFEE));

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
